// File: rtl/gf163_seq_alu.sv
// gf163_seq_alu: digit-serial GF(2^163) multiply/square unit, f(x) = x^163 + x^7 + x^6 + x^3 + 1.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   DA, DB              operands, captured on the start edge only
//   Mul_enable          start strobe, BP_OUT1 = DA*DB mod f (wins over SQA_opt)
//   SQA_opt             start strobe, BP_OUT2 = DA^2 mod f, SS_OUT = BP_OUT2 ^ DB
//   BP_OUT1/2, SS_OUT   result registers, written only in DONE
//   alu_done            one-cycle completion pulse
//   alu_busy            high from the start edge until alu_done deasserts
module gf163_seq_alu #(
  parameter int unsigned DIGIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [162:0] DA,
  input  logic [162:0] DB,
  input  logic         Mul_enable,
  input  logic         SQA_opt,
  output logic [162:0] BP_OUT1,
  output logic [162:0] BP_OUT2,
  output logic [162:0] SS_OUT,
  output logic         alu_done,
  output logic         alu_busy
);

  localparam int unsigned W     = 163;
  localparam int unsigned ITER  = (W + DIGIT - 1) / DIGIT;
  localparam int unsigned EXT_W = ITER * DIGIT;
  localparam int unsigned CNT_W = $clog2(ITER + 1);
  localparam int unsigned IDX_W = $clog2(EXT_W);
  // Low-order terms of x^163 mod f: x^7 + x^6 + x^3 + 1.
  localparam logic [W-1:0] RED  = W'(8'hC9);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic               op_mul;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       addend_q;
  logic [W-1:0]       acc;
  logic [CNT_W-1:0]   cnt;

  logic [EXT_W-1:0]   b_ext;
  logic [IDX_W-1:0]   digit_idx;
  logic [DIGIT-1:0]   digit;
  logic [W-1:0]       acc_next;

  // Multiply by x and fold x^163 back into the low terms.
  function automatic logic [W-1:0] mul_x(input logic [W-1:0] v);
    return {v[W-2:0], 1'b0} ^ (v[W-1] ? RED : '0);
  endfunction

  // One RUN step: Horner over the digit bits, MSB first, equals acc*x^DIGIT + A*d mod f.
  always_comb begin
    b_ext     = EXT_W'(b_q);
    digit_idx = (IDX_W'(ITER - 1) - IDX_W'(cnt)) * IDX_W'(DIGIT);
    digit     = b_ext[digit_idx +: DIGIT];
    acc_next  = acc;
    for (int j = int'(DIGIT) - 1; j >= 0; j--) begin
      acc_next = mul_x(acc_next) ^ (digit[j] ? a_q : '0);
    end
  end

  // Control FSM with registered results and handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_mul   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      addend_q <= '0;
      acc      <= '0;
      cnt      <= '0;
      BP_OUT1  <= '0;
      BP_OUT2  <= '0;
      SS_OUT   <= '0;
      alu_done <= 1'b0;
      alu_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          alu_done <= 1'b0;
          if (Mul_enable || SQA_opt) begin
            a_q      <= DA;
            b_q      <= Mul_enable ? DB : DA;
            addend_q <= DB;
            op_mul   <= Mul_enable;
            acc      <= '0;
            cnt      <= '0;
            alu_busy <= 1'b1;
            state    <= RUN;
          end else begin
            alu_busy <= 1'b0;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) state <= DONE;
        end
        DONE: begin
          if (op_mul) begin
            BP_OUT1 <= acc;
          end else begin
            BP_OUT2 <= acc;
            SS_OUT  <= acc ^ addend_q;
          end
          // Busy stays high through the done pulse; IDLE drops it unless restarted.
          alu_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf163_seq_alu.sv
// tb_gf163_seq_alu: directed and random checks of gf163_seq_alu at DIGIT = 1, 4, 8 in parallel.
module tb_gf163_seq_alu;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [162:0] DA, DB;
  logic         Mul_enable, SQA_opt;

  logic [162:0] bp1 [N];
  logic [162:0] bp2 [N];
  logic [162:0] ss  [N];
  logic         done [N];
  logic         busy [N];

  int checks = 0;
  int errors = 0;

  int done_cnt  [N];
  int done_lat  [N];
  int busy_drop [N];

  logic [162:0] e1 [N];
  logic [162:0] e2 [N];
  logic [162:0] es [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    gf163_seq_alu #(.DIGIT(g == 0 ? 1 : (g == 1 ? 4 : 8))) u_dut (
      .clk        (clk),
      .rst        (rst),
      .DA         (DA),
      .DB         (DB),
      .Mul_enable (Mul_enable),
      .SQA_opt    (SQA_opt),
      .BP_OUT1    (bp1[g]),
      .BP_OUT2    (bp2[g]),
      .SS_OUT     (ss[g]),
      .alu_done   (done[g]),
      .alu_busy   (busy[g])
    );
  end

  // Edges from the start edge to the done pulse: ceil(163/DIGIT) + 1.
  function automatic int lat_of(input int g);
    case (g)
      0:       return 164;
      1:       return 42;
      default: return 22;
    endcase
  endfunction

  // Schoolbook product followed by top-down reduction.
  function automatic logic [162:0] ref_mul(input logic [162:0] a, input logic [162:0] b);
    logic [324:0] p;
    p = '0;
    for (int i = 0; i < 163; i++) if (b[i]) p = p ^ (325'(a) << i);
    for (int i = 324; i >= 163; i--) begin
      if (p[i]) begin
        p[i]       = 1'b0;
        p[i-163]   = ~p[i-163];
        p[i-160]   = ~p[i-160];
        p[i-157]   = ~p[i-157];
        p[i-156]   = ~p[i-156];
      end
    end
    return p[162:0];
  endfunction

  function automatic logic [162:0] rand163();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[162:0];
  endfunction

  // Issue one strobe (held 'hold' edges), optional extra Mul pulse at pulse_at, operands
  // scrambled right after the start edge; record done pulses and busy drops for 175 edges.
  task automatic run_op(input logic [162:0] a, input logic [162:0] b, input logic m,
                        input logic s, input int hold, input int pulse_at);
    for (int g = 0; g < N; g++) begin
      done_cnt[g] = 0; done_lat[g] = -1; busy_drop[g] = 0;
    end
    @(negedge clk);
    DA = a; DB = b; Mul_enable = m; SQA_opt = s;
    for (int k = 0; k <= 175; k++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        if (done[g] === 1'b1) begin
          done_cnt[g]++;
          done_lat[g] = k;
        end
        if (busy[g] !== 1'b1 && (done_lat[g] < 0 || done_lat[g] == k)) busy_drop[g]++;
      end
      if (k + 1 >= hold) begin Mul_enable = 1'b0; SQA_opt = 1'b0; end
      if (k == 1) begin DA = ~a; DB = ~b; end
      if (k == pulse_at) Mul_enable = 1'b1;
    end
    Mul_enable = 1'b0; SQA_opt = 1'b0;
  endtask

  task automatic test_reset();
    for (int g = 0; g < N; g++) begin
      checks++;
      if ({bp1[g], bp2[g], ss[g], done[g], busy[g]} !== '0) begin
        errors++;
        $display("FAIL reset inst%0d: got %h/%h/%h done=%b busy=%b, want all 0",
                 g, bp1[g], bp2[g], ss[g], done[g], busy[g]);
      end
      e1[g] = '0; e2[g] = '0; es[g] = '0;
    end
  endtask

  task automatic test_mul_unit();
    run_op(163'd1, 163'd1, 1'b1, 1'b0, 1, -1);
    for (int g = 0; g < N; g++) begin
      e1[g] = 163'd1;
      checks++;
      if (done_cnt[g] !== 1 || done_lat[g] !== lat_of(g)) begin
        errors++;
        $display("FAIL mul_unit done inst%0d: got cnt=%0d lat=%0d, want 1/%0d", g, done_cnt[g], done_lat[g], lat_of(g));
      end
      checks++;
      if (busy_drop[g] !== 0) begin
        errors++; $display("FAIL mul_unit busy inst%0d: got %0d low cycles, want 0", g, busy_drop[g]);
      end
      checks++;
      if ({bp1[g], bp2[g], ss[g]} !== {e1[g], e2[g], es[g]}) begin
        errors++;
        $display("FAIL mul_unit result inst%0d: got %h %h %h want %h %h %h", g, bp1[g], bp2[g], ss[g], e1[g], e2[g], es[g]);
      end
    end
  endtask

  task automatic test_mul_reduce();
    run_op(163'h2, 163'd1 << 162, 1'b1, 1'b0, 1, -1);
    for (int g = 0; g < N; g++) begin
      e1[g] = 163'hC9;
      checks++;
      if (done_cnt[g] !== 1 || done_lat[g] !== lat_of(g)) begin
        errors++;
        $display("FAIL mul_reduce done inst%0d: got cnt=%0d lat=%0d, want 1/%0d", g, done_cnt[g], done_lat[g], lat_of(g));
      end
      checks++;
      if ({bp1[g], bp2[g], ss[g]} !== {e1[g], e2[g], es[g]}) begin
        errors++;
        $display("FAIL mul_reduce result inst%0d: got %h %h %h want %h %h %h", g, bp1[g], bp2[g], ss[g], e1[g], e2[g], es[g]);
      end
    end
  endtask

  task automatic test_square();
    run_op(163'd1 << 81, 163'd1, 1'b0, 1'b1, 1, -1);
    for (int g = 0; g < N; g++) begin
      e2[g] = 163'd1 << 162;
      es[g] = (163'd1 << 162) | 163'd1;
      checks++;
      if (done_cnt[g] !== 1 || done_lat[g] !== lat_of(g) || busy_drop[g] !== 0) begin
        errors++;
        $display("FAIL square done inst%0d: got cnt=%0d lat=%0d drop=%0d, want 1/%0d/0",
                 g, done_cnt[g], done_lat[g], busy_drop[g], lat_of(g));
      end
      checks++;
      if ({bp1[g], bp2[g], ss[g]} !== {e1[g], e2[g], es[g]}) begin
        errors++;
        $display("FAIL square result inst%0d: got %h %h %h want %h %h %h", g, bp1[g], bp2[g], ss[g], e1[g], e2[g], es[g]);
      end
    end
  endtask

  task automatic test_both_strobes();
    run_op(163'd3, 163'd3, 1'b1, 1'b1, 1, 10);
    for (int g = 0; g < N; g++) begin
      e1[g] = 163'd5;
      checks++;
      if (done_cnt[g] !== 1 || done_lat[g] !== lat_of(g)) begin
        errors++;
        $display("FAIL both_strobes done inst%0d: got cnt=%0d lat=%0d, want 1/%0d", g, done_cnt[g], done_lat[g], lat_of(g));
      end
      checks++;
      if ({bp1[g], bp2[g], ss[g]} !== {e1[g], e2[g], es[g]}) begin
        errors++;
        $display("FAIL both_strobes result inst%0d: got %h %h %h want %h %h %h", g, bp1[g], bp2[g], ss[g], e1[g], e2[g], es[g]);
      end
    end
  endtask

  // Strobe held 44 edges: DIGIT 4/8 finish and restart on the still-high strobe with the
  // operands changed after the first start edge; DIGIT 1 is still running and ignores it.
  task automatic test_back_to_back();
    logic [162:0] n3;
    int exp_cnt [N];
    int exp_lat [N];
    n3 = ~163'd3;
    exp_cnt = '{1, 2, 2};
    exp_lat = '{164, 85, 45};
    run_op(163'd3, 163'd3, 1'b1, 1'b0, 44, -1);
    for (int g = 0; g < N; g++) begin
      e1[g] = (g == 0) ? 163'd5 : ref_mul(n3, n3);
      checks++;
      if (done_cnt[g] !== exp_cnt[g] || done_lat[g] !== exp_lat[g] || busy_drop[g] !== 0) begin
        errors++;
        $display("FAIL back_to_back done inst%0d: got cnt=%0d lat=%0d drop=%0d, want %0d/%0d/0",
                 g, done_cnt[g], done_lat[g], busy_drop[g], exp_cnt[g], exp_lat[g]);
      end
      checks++;
      if ({bp1[g], bp2[g], ss[g]} !== {e1[g], e2[g], es[g]}) begin
        errors++;
        $display("FAIL back_to_back result inst%0d: got %h %h %h want %h %h %h", g, bp1[g], bp2[g], ss[g], e1[g], e2[g], es[g]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    DA = rand163(); DB = rand163(); Mul_enable = 1'b1;
    @(negedge clk);
    Mul_enable = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < N; g++) begin
      checks++;
      if ({bp1[g], bp2[g], ss[g], done[g], busy[g]} !== '0) begin
        errors++;
        $display("FAIL reset_mid inst%0d: got %h/%h/%h done=%b busy=%b, want all 0",
                 g, bp1[g], bp2[g], ss[g], done[g], busy[g]);
      end
      e1[g] = '0; e2[g] = '0; es[g] = '0;
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) if (done[g] !== 1'b0 || busy[g] !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_mid abort: got %0d done/busy samples after reset, want 0", seen);
    end
    run_op(163'd3, 163'd3, 1'b1, 1'b0, 1, -1);
    for (int g = 0; g < N; g++) begin
      e1[g] = 163'd5;
      checks++;
      if (done_cnt[g] !== 1 || {bp1[g], bp2[g], ss[g]} !== {e1[g], e2[g], es[g]}) begin
        errors++;
        $display("FAIL reset_mid resume inst%0d: got cnt=%0d bp1=%h, want 1/%h", g, done_cnt[g], bp1[g], e1[g]);
      end
    end
  endtask

  task automatic test_random();
    logic [162:0] a, b;
    logic m;
    for (int t = 0; t < 30; t++) begin
      a = rand163(); b = rand163(); m = 1'($urandom_range(0, 1));
      run_op(a, b, m, ~m, 1, -1);
      for (int g = 0; g < N; g++) begin
        if (m) begin
          e1[g] = ref_mul(a, b);
        end else begin
          e2[g] = ref_mul(a, a);
          es[g] = e2[g] ^ b;
        end
        checks++;
        if (done_cnt[g] !== 1 || done_lat[g] !== lat_of(g) || busy_drop[g] !== 0) begin
          errors++;
          $display("FAIL random%0d done inst%0d: got cnt=%0d lat=%0d drop=%0d, want 1/%0d/0",
                   t, g, done_cnt[g], done_lat[g], busy_drop[g], lat_of(g));
        end
        checks++;
        if ({bp1[g], bp2[g], ss[g]} !== {e1[g], e2[g], es[g]}) begin
          errors++;
          $display("FAIL random%0d result inst%0d: got %h %h %h want %h %h %h", t, g, bp1[g], bp2[g], ss[g], e1[g], e2[g], es[g]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; DA = '0; DB = '0; Mul_enable = 1'b0; SQA_opt = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_mul_unit();
    test_mul_reduce();
    test_square();
    test_both_strobes();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
